// File: rtl/systolic_feeder.sv
// rtl/systolic_feeder.sv - captures A/B and streams them diagonally skewed into an NxN systolic array
module systolic_feeder #(
    parameter int MATRIX_SIZE  = 3,
    parameter int DATA_SIZE    = 8,
    parameter int DRAIN_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic                 ready,
    input  logic [DATA_SIZE-1:0] mat_a [MATRIX_SIZE*MATRIX_SIZE],
    input  logic [DATA_SIZE-1:0] mat_b [MATRIX_SIZE*MATRIX_SIZE],
    output logic [DATA_SIZE-1:0] feed_a [MATRIX_SIZE],
    output logic [DATA_SIZE-1:0] feed_b [MATRIX_SIZE],
    output logic                 array_clear,
    output logic                 busy,
    output logic                 done
);
    localparam int N  = MATRIX_SIZE;
    localparam int NN = N * N;
    localparam int CW = $clog2(3 * N);
    localparam int IW = $clog2(NN);
    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_BEAT  = CW'(3 * N - 3);
    localparam logic [DW-1:0] LAST_DRAIN = DW'(DRAIN_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, DONE} state_t;

    state_t               state;
    logic [CW-1:0]        beat;
    logic [DW-1:0]        drain_cnt;
    logic [DATA_SIZE-1:0] a_q [NN];
    logic [DATA_SIZE-1:0] b_q [NN];
    logic [CW-1:0]        next_beat;
    logic [DATA_SIZE-1:0] lane_a [N];
    logic [DATA_SIZE-1:0] lane_b [N];
    int                   lane_k;

    // Feed values for the beat about to be registered; lanes outside the diagonal band carry zero.
    always_comb begin
        next_beat = (state == STREAM) ? beat + CW'(1) : '0;
        lane_k    = 0;
        for (int i = 0; i < N; i++) begin
            lane_a[i] = '0;
            lane_b[i] = '0;
            lane_k    = int'(next_beat) - i;
            if (lane_k >= 0 && lane_k < N) begin
                lane_a[i] = a_q[IW'(i * N + lane_k)];
                lane_b[i] = b_q[IW'(lane_k * N + i)];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            ready       <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            array_clear <= 1'b0;
            beat        <= '0;
            drain_cnt   <= '0;
            for (int k = 0; k < NN; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
            end
            for (int i = 0; i < N; i++) begin
                feed_a[i] <= '0;
                feed_b[i] <= '0;
            end
        end else begin
            done        <= 1'b0;
            array_clear <= 1'b0;
            for (int i = 0; i < N; i++) begin
                feed_a[i] <= '0;
                feed_b[i] <= '0;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q         <= mat_a;
                        b_q         <= mat_b;
                        state       <= CLEAR;
                        ready       <= 1'b0;
                        busy        <= 1'b1;
                        array_clear <= 1'b1;
                    end
                end
                CLEAR: begin
                    state  <= STREAM;
                    beat   <= '0;
                    feed_a <= lane_a;
                    feed_b <= lane_b;
                end
                STREAM: begin
                    if (beat == LAST_BEAT) begin
                        state     <= DRAIN;
                        beat      <= '0;
                        drain_cnt <= '0;
                    end else begin
                        beat   <= next_beat;
                        feed_a <= lane_a;
                        feed_b <= lane_b;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == LAST_DRAIN) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + DW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
